// File: rtl/next_pc_unit.sv
// -----------------------------------------------------------------------------
// next_pc_unit
//   Next-PC generator for the MIPS core. Owns the fetch PC register, resolves
//   beq/bne/j/jal/jr redirects from the resolve stage, keeps a circular
//   return-address stack (RAS) used to check jr targets, and counts taken
//   redirects and RAS misses with saturating counters. PC is a word address.
//
// Ports
//   clk_i              rising-edge clock
//   rst_n_i            synchronous active-low reset
//   stall_i            hold pc when there is no redirect
//   rs_valid_i         resolve-stage instruction valid
//   rs_pc_i            PC of the resolving instruction
//   branch_i           00 none, 01 beq, 10 bne, 11 none
//   jump_i             00 none, 01 jr, 10 jal, 11 j
//   equal_i            rs==rt compare result
//   in_branch_i        sign-extended branch offset (words)
//   in_j_i             jump immediate
//   in_jr_i            register target for jr
//   pc_o               current fetch PC (registered)
//   redirect_o         taken branch/jump this cycle (combinational flush strobe)
//   redirect_target_o  redirect target, zero when no redirect
//   ras_hit_o          jr valid, RAS non-empty and top == in_jr_i
//   ras_count_o        number of valid RAS entries
//   redirect_cnt_o     taken redirects since reset (saturating)
//   ras_miss_cnt_o     jr instructions that missed the RAS (saturating)
// -----------------------------------------------------------------------------
module next_pc_unit #(
   parameter int unsigned      PC_W      = 32,
   parameter int unsigned      J_W       = 26,
   parameter logic [PC_W-1:0]  RESET_PC  = {PC_W{1'b0}},
   parameter int unsigned      RAS_DEPTH = 4,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         stall_i,
   input  logic                         rs_valid_i,
   input  logic [PC_W-1:0]              rs_pc_i,
   input  logic [1:0]                   branch_i,
   input  logic [1:0]                   jump_i,
   input  logic                         equal_i,
   input  logic [PC_W-1:0]              in_branch_i,
   input  logic [J_W-1:0]               in_j_i,
   input  logic [PC_W-1:0]              in_jr_i,
   output logic [PC_W-1:0]              pc_o,
   output logic                         redirect_o,
   output logic [PC_W-1:0]              redirect_target_o,
   output logic                         ras_hit_o,
   output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
   output logic [CNT_W-1:0]             redirect_cnt_o,
   output logic [CNT_W-1:0]             ras_miss_cnt_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned RCW   = PTR_W + 1;
   localparam logic [RCW-1:0]  RAS_FULL = RCW'(RAS_DEPTH);
   localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1'b1);

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1'b1);
      end
   endfunction

   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PTR_W-1:0] sp_q, sp_d;
   logic [RCW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] rdr_cnt_q, rdr_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];

   logic             redirect_s;
   logic [PC_W-1:0]  target_s;
   logic             is_jr_s;
   logic             is_jal_s;
   logic             br_taken_s;
   logic [PC_W-1:0]  jtarget_s;
   logic [PTR_W-1:0] top_idx_s;
   logic             ras_hit_s;

   assign br_taken_s = ((branch_i == 2'b01) && equal_i) || ((branch_i == 2'b10) && !equal_i);
   assign jtarget_s  = {rs_pc_i[PC_W-1:J_W], in_j_i};
   // sp_q points at the next free slot, so the top entry is one below it.
   assign top_idx_s  = sp_q - PTR_W'(1'b1);

   // Decode the resolving instruction into a redirect and RAS push/pop strobes.
   always_comb begin
      redirect_s = 1'b0;
      target_s   = {PC_W{1'b0}};
      is_jr_s    = 1'b0;
      is_jal_s   = 1'b0;
      if (rs_valid_i) begin
         case (jump_i)
            2'b01: begin
               redirect_s = 1'b1;
               target_s   = in_jr_i;
               is_jr_s    = 1'b1;
            end
            2'b10: begin
               redirect_s = 1'b1;
               target_s   = jtarget_s;
               is_jal_s   = 1'b1;
            end
            2'b11: begin
               redirect_s = 1'b1;
               target_s   = jtarget_s;
            end
            default: begin
               if (br_taken_s) begin
                  redirect_s = 1'b1;
                  target_s   = rs_pc_i + in_branch_i + PC_ONE;
               end else begin
                  redirect_s = 1'b0;
                  target_s   = {PC_W{1'b0}};
               end
            end
         endcase
      end else begin
         redirect_s = 1'b0;
         target_s   = {PC_W{1'b0}};
      end
   end

   // The top is compared before this cycle's pop takes effect.
   assign ras_hit_s = is_jr_s && (cnt_q != {RCW{1'b0}}) && (ras_mem_q[top_idx_s] == in_jr_i);

   // Next-state for pc, RAS pointer/count and the performance counters.
   always_comb begin
      pc_d       = pc_q;
      sp_d       = sp_q;
      cnt_d      = cnt_q;
      rdr_cnt_d  = rdr_cnt_q;
      miss_cnt_d = miss_cnt_q;

      if (redirect_s) begin
         pc_d      = target_s;
         rdr_cnt_d = sat_inc(rdr_cnt_q);
      end else if (stall_i) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_q + PC_ONE;
      end

      // A full push wraps onto the oldest slot; the count stays at depth.
      if (is_jal_s) begin
         sp_d = sp_q + PTR_W'(1'b1);
         if (cnt_q == RAS_FULL) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + RCW'(1'b1);
         end
      end else if (is_jr_s) begin
         if (cnt_q != {RCW{1'b0}}) begin
            sp_d  = top_idx_s;
            cnt_d = cnt_q - RCW'(1'b1);
         end else begin
            sp_d  = sp_q;
            cnt_d = cnt_q;
         end
      end else begin
         sp_d  = sp_q;
         cnt_d = cnt_q;
      end

      if (is_jr_s && !ras_hit_s) begin
         miss_cnt_d = sat_inc(miss_cnt_q);
      end else begin
         miss_cnt_d = miss_cnt_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pc_q       <= RESET_PC;
         sp_q       <= {PTR_W{1'b0}};
         cnt_q      <= {RCW{1'b0}};
         rdr_cnt_q  <= {CNT_W{1'b0}};
         miss_cnt_q <= {CNT_W{1'b0}};
      end else begin
         pc_q       <= pc_d;
         sp_q       <= sp_d;
         cnt_q      <= cnt_d;
         rdr_cnt_q  <= rdr_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // RAS storage; entries are never cleared because the count gates their use.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && is_jal_s) begin
         ras_mem_q[sp_q] <= rs_pc_i + PC_ONE;
      end
   end

   assign pc_o              = pc_q;
   assign redirect_o        = redirect_s;
   assign redirect_target_o = target_s;
   assign ras_hit_o         = ras_hit_s;
   assign ras_count_o       = cnt_q;
   assign redirect_cnt_o    = rdr_cnt_q;
   assign ras_miss_cnt_o    = miss_cnt_q;

endmodule
